// File: rtl/noc_to_axis_adapter.sv
// noc_to_axis_adapter
// Egress stage of the NoC-to-AXI-Stream bridge. Flits from a router output
// port are buffered in a DEPTH-entry FIFO and replayed as an AXI-Stream
// master. A one-cycle credit pulse goes back to the router for every flit
// drained. A framing checker watches the head/tail sequence of accepted flits.
//
// Optional build macro: NOC2AXIS_STATS_EN adds flit_count / pkt_count.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   channel_in      flit: [AXIW+3] valid, [AXIW+2] head, [AXIW+1] tail,
//                   [AXIW] reserved (ignored), [AXIW-1:0] payload
//   flow_ctrl_out   credit pulse, one cycle per flit dequeued
//   axis_tvalid/axis_tready/axis_tdata/axis_tlast  AXI-Stream master
//   fifo_empty, fifo_full  FIFO occupancy flags
//   err_overflow    sticky: flit arrived while full with no pop that cycle
//   err_framing     sticky: head/tail sequence violation
//   flit_count, pkt_count  (NOC2AXIS_STATS_EN only) handshake counters
//
// Handshake: a beat transfers on a rising edge where axis_tvalid and
// axis_tready are both high; axis_tvalid, axis_tdata and axis_tlast are held
// until that happens. channel_in has no backpressure: the router only sends
// with a credit in hand, so a flit arriving at a full FIFO is dropped.
module noc_to_axis_adapter #(
    parameter int AXIW  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AXIW+3:0] channel_in,
    output logic            flow_ctrl_out,
    output logic            axis_tvalid,
    input  logic            axis_tready,
    output logic [AXIW-1:0] axis_tdata,
    output logic            axis_tlast,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic            err_overflow,
    output logic            err_framing
`ifdef NOC2AXIS_STATS_EN
    ,
    output logic [15:0]     flit_count,
    output logic [15:0]     pkt_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

    // Each entry holds {tail, payload}; head is only needed by the framing check.
    logic [AXIW:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;

    logic           in_valid;
    logic           in_head;
    logic           in_tail;
    logic           push;
    logic           pop;
    logic           unused_rsvd;

    frame_state_t   frame_state;
    frame_state_t   frame_state_next;
    logic           frame_err;

    assign in_valid    = channel_in[AXIW+3];
    assign in_head     = channel_in[AXIW+2];
    assign in_tail     = channel_in[AXIW+1];
    assign unused_rsvd = channel_in[AXIW];

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FULL_COUNT);

    assign pop  = axis_tvalid & axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = in_valid & (~fifo_full | pop);

    // Output comes straight from the registered head entry; tvalid depends
    // only on the registered count, so there is no input-to-output path.
    assign axis_tvalid = ~fifo_empty;
    assign axis_tdata  = fifo_empty ? '0   : mem[rd_ptr][AXIW-1:0];
    assign axis_tlast  = fifo_empty ? 1'b0 : mem[rd_ptr][AXIW];

    // Storage array carries no reset; unread entries are masked by fifo_empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_tail, channel_in[AXIW-1:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            flow_ctrl_out <= 1'b0;
            err_overflow  <= 1'b0;
            err_framing   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            flow_ctrl_out <= pop;
            if (in_valid && fifo_full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (frame_err) begin
                err_framing <= 1'b1;
            end
        end
    end

    // Framing FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_state <= IDLE;
        end else begin
            frame_state <= frame_state_next;
        end
    end

    // Framing FSM: next state. Only accepted flits advance it; a misplaced
    // head inside a packet restarts framing from that head.
    always_comb begin
        frame_state_next = frame_state;
        frame_err        = 1'b0;
        if (push) begin
            case (frame_state)
                IDLE: begin
                    if (in_head) begin
                        frame_state_next = in_tail ? IDLE : IN_PKT;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (in_head) begin
                        frame_err        = 1'b1;
                        frame_state_next = in_tail ? IDLE : IN_PKT;
                    end else if (in_tail) begin
                        frame_state_next = IDLE;
                    end
                end
                default: frame_state_next = IDLE;
            endcase
        end
    end

`ifdef NOC2AXIS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_count <= '0;
            pkt_count  <= '0;
        end else if (pop) begin
            flit_count <= flit_count + 16'd1;
            if (axis_tlast) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_to_axis_adapter.sv
// Testbench for noc_to_axis_adapter: directed scenarios plus a randomized
// run, all checked against a queue-based reference model of the adapter.
module tb_noc_to_axis_adapter;

    localparam int AXIW  = 32;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AXIW+3:0] channel_in = '0;
    logic            axis_tready = 1'b0;
    logic            flow_ctrl_out;
    logic            axis_tvalid;
    logic [AXIW-1:0] axis_tdata;
    logic            axis_tlast;
    logic            fifo_empty;
    logic            fifo_full;
    logic            err_overflow;
    logic            err_framing;
`ifdef NOC2AXIS_STATS_EN
    logic [15:0]     flit_count;
    logic [15:0]     pkt_count;
`endif

    always #5 clk = ~clk;

    noc_to_axis_adapter #(.AXIW(AXIW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .channel_in    (channel_in),
        .flow_ctrl_out (flow_ctrl_out),
        .axis_tvalid   (axis_tvalid),
        .axis_tready   (axis_tready),
        .axis_tdata    (axis_tdata),
        .axis_tlast    (axis_tlast),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .err_overflow  (err_overflow),
        .err_framing   (err_framing)
`ifdef NOC2AXIS_STATS_EN
        ,
        .flit_count    (flit_count),
        .pkt_count     (pkt_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cred_seen = 0;

    // ---------------- reference model ----------------
    // m_q holds the flits the adapter should currently be buffering, oldest
    // first. exp_q collects beats the model says were delivered; got_q the
    // beats actually seen on the AXIS port.
    logic [AXIW:0] m_q[$];
    logic [AXIW:0] exp_q[$];
    logic [AXIW:0] got_q[$];
    logic          m_credit = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_frm = 1'b0;
    logic          m_in_pkt = 1'b0;
    logic [15:0]   m_flits = '0;
    logic [15:0]   m_pkts = '0;

    always @(posedge clk or posedge rst) begin : model
        logic do_pop;
        logic hd;
        logic tl;
        if (rst) begin
            m_q.delete();
            m_credit = 1'b0;
            m_ovf    = 1'b0;
            m_frm    = 1'b0;
            m_in_pkt = 1'b0;
            m_flits  = '0;
            m_pkts   = '0;
        end else begin
            do_pop   = (m_q.size() != 0) && axis_tready;
            m_credit = do_pop;
            if (do_pop) begin
                exp_q.push_back(m_q[0]);
                m_flits = m_flits + 16'd1;
                if (m_q[0][AXIW]) m_pkts = m_pkts + 16'd1;
                void'(m_q.pop_front());
            end
            if (channel_in[AXIW+3]) begin
                if (m_q.size() < DEPTH) begin
                    hd = channel_in[AXIW+2];
                    tl = channel_in[AXIW+1];
                    // A head is legal only outside a packet, a non-head only inside.
                    if (hd == m_in_pkt) m_frm = 1'b1;
                    if (hd || m_in_pkt) m_in_pkt = ~tl;
                    m_q.push_back({tl, channel_in[AXIW-1:0]});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && axis_tvalid && axis_tready) got_q.push_back({axis_tlast, axis_tdata});
    end

    always @(negedge clk) begin
        if (flow_ctrl_out) cred_seen++;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [AXIW+3:0] flit(input logic h, input logic t, input logic [AXIW-1:0] d);
        return {1'b1, h, t, 1'b0, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        channel_in = '0;
        axis_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        cred_seen = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %0b want 0", axis_tvalid); end
        n_cmp++; if (axis_tdata !== '0) begin n_err++; $display("FAIL reset_tdata got %0h want 0", axis_tdata); end
        n_cmp++; if (axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %0b want 0", axis_tlast); end
        n_cmp++; if (flow_ctrl_out !== 1'b0) begin n_err++; $display("FAIL reset_flow got %0b want 0", flow_ctrl_out); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b want 1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", fifo_full); end
        n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", err_overflow); end
        n_cmp++; if (err_framing !== 1'b0) begin n_err++; $display("FAIL reset_frm got %0b want 0", err_framing); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        axis_tready = 1'b1;
        channel_in = flit(1'b1, 1'b1, 32'hAABBCCDD);
        #1;
        n_cmp++; if (axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_passthru tvalid got %0b want 0", axis_tvalid); end
        @(negedge clk);
        channel_in = '0;
        n_cmp++; if (axis_tvalid !== 1'b1) begin n_err++; $display("FAIL single_tvalid got %0b want 1", axis_tvalid); end
        n_cmp++; if (axis_tdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL single_tdata got %0h want aabbccdd", axis_tdata); end
        n_cmp++; if (axis_tlast !== 1'b1) begin n_err++; $display("FAIL single_tlast got %0b want 1", axis_tlast); end
        n_cmp++; if (flow_ctrl_out !== 1'b0) begin n_err++; $display("FAIL single_flow_early got %0b want 0", flow_ctrl_out); end
        @(negedge clk);
        n_cmp++; if (flow_ctrl_out !== 1'b1) begin n_err++; $display("FAIL single_flow_pulse got %0b want 1", flow_ctrl_out); end
        n_cmp++; if (axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_drained tvalid got %0b want 0", axis_tvalid); end
        @(negedge clk);
        n_cmp++; if (flow_ctrl_out !== 1'b0) begin n_err++; $display("FAIL single_flow_end got %0b want 0", flow_ctrl_out); end
    endtask

    task automatic test_packet();
        logic [AXIW:0] want [3];
        want[0] = {1'b0, 32'h11223344};
        want[1] = {1'b0, 32'h55667788};
        want[2] = {1'b1, 32'hDEADBEEF};
        do_reset();
        axis_tready = 1'b1;
        channel_in = flit(1'b1, 1'b0, 32'h11223344);
        @(negedge clk);
        channel_in = flit(1'b0, 1'b0, 32'h55667788);
        @(negedge clk);
        channel_in = flit(1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        channel_in = '0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (flow_ctrl_out !== m_credit) begin n_err++; $display("FAIL pkt_flow cyc %0d got %0b want %0b", i, flow_ctrl_out, m_credit); end
            @(negedge clk);
        end
        n_cmp++; if (got_q.size() != 3) begin n_err++; $display("FAIL pkt_beats got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== want[i]) begin n_err++; $display("FAIL pkt_beat%0d got %0h want %0h", i, got_q[i], want[i]); end
        end
        n_cmp++; if (cred_seen != 3) begin n_err++; $display("FAIL pkt_credits got %0d want 3", cred_seen); end
        n_cmp++; if (err_framing !== 1'b0) begin n_err++; $display("FAIL pkt_framing got %0b want 0", err_framing); end
    endtask

    task automatic test_overflow();
        logic [AXIW-1:0] pay [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pay[i] = $urandom;
            channel_in = flit(1'b1, 1'b1, pay[i]);
            @(negedge clk);
            n_cmp++; if (axis_tdata !== pay[0]) begin n_err++; $display("FAIL ovf_hold%0d got %0h want %0h", i, axis_tdata, pay[0]); end
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %0b want 1", fifo_full); end
        n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early got %0b want 0", err_overflow); end
        channel_in = flit(1'b1, 1'b1, $urandom);
        @(negedge clk);
        channel_in = '0;
        n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", err_overflow); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_still_full got %0b want 1", fifo_full); end
        axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        n_cmp++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL ovf_beats got %0d want %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== {1'b1, pay[i]}) begin n_err++; $display("FAIL ovf_beat%0d got %0h want %0h", i, got_q[i], {1'b1, pay[i]}); end
        end
        n_cmp++; if (cred_seen != DEPTH) begin n_err++; $display("FAIL ovf_credits got %0d want %0d", cred_seen, DEPTH); end
        n_cmp++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", err_overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [AXIW-1:0] pay [DEPTH+1];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            pay[i] = $urandom;
            channel_in = flit(1'b1, 1'b1, pay[i]);
            @(negedge clk);
        end
        pay[DEPTH] = $urandom;
        axis_tready = 1'b1;
        channel_in = flit(1'b1, 1'b1, pay[DEPTH]);
        @(negedge clk);
        channel_in = '0;
        axis_tready = 1'b0;
        n_cmp++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %0b want 0", err_overflow); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fpp_full got %0b want 1", fifo_full); end
        axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        n_cmp++; if (got_q.size() != DEPTH + 1) begin n_err++; $display("FAIL fpp_beats got %0d want %0d", got_q.size(), DEPTH + 1); end
        for (int i = 0; i <= DEPTH && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i][AXIW-1:0] !== pay[i]) begin n_err++; $display("FAIL fpp_beat%0d got %0h want %0h", i, got_q[i][AXIW-1:0], pay[i]); end
        end
        n_cmp++; if (cred_seen != DEPTH + 1) begin n_err++; $display("FAIL fpp_credits got %0d want %0d", cred_seen, DEPTH + 1); end
    endtask

    task automatic test_framing_and_reset();
        logic [AXIW-1:0] body;
        body = $urandom;
        do_reset();
        channel_in = flit(1'b0, 1'b0, body);
        @(negedge clk);
        channel_in = '0;
        n_cmp++; if (err_framing !== 1'b1) begin n_err++; $display("FAIL frm_flag got %0b want 1", err_framing); end
        axis_tready = 1'b1;
        @(negedge clk);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== {1'b0, body}) begin n_err++; $display("FAIL frm_delivered got %0d beats want 1 beat %0h", got_q.size(), body); end
        axis_tready = 1'b0;
        channel_in = flit(1'b1, 1'b0, $urandom);
        @(negedge clk);
        channel_in = flit(1'b0, 1'b0, $urandom);
        @(negedge clk);
        channel_in = '0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (axis_tvalid !== 1'b0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_err++; $display("FAIL midrst_fifo got v%0b e%0b f%0b want v0 e1 f0", axis_tvalid, fifo_empty, fifo_full); end
        n_cmp++; if (axis_tdata !== '0 || axis_tlast !== 1'b0) begin n_err++; $display("FAIL midrst_data got %0h/%0b want 0/0", axis_tdata, axis_tlast); end
        n_cmp++; if (err_framing !== 1'b0 || err_overflow !== 1'b0 || flow_ctrl_out !== 1'b0) begin n_err++; $display("FAIL midrst_flags got frm%0b ovf%0b flow%0b want 0", err_framing, err_overflow, flow_ctrl_out); end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        cred_seen = 0;
        axis_tready = 1'b1;
        @(negedge clk);
        n_cmp++; if (flow_ctrl_out !== 1'b0) begin n_err++; $display("FAIL midrst_credit got %0b want 0", flow_ctrl_out); end
        channel_in = flit(1'b1, 1'b1, 32'h0BADF00D);
        @(negedge clk);
        channel_in = '0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_cmp++; if (got_q.size() != 1 || got_q[0] !== {1'b1, 32'h0BADF00D}) begin n_err++; $display("FAIL postrst_beat got %0d beats want 1 beat 0badf00d", got_q.size()); end
        n_cmp++; if (err_framing !== 1'b0) begin n_err++; $display("FAIL postrst_frm got %0b want 0", err_framing); end
        n_cmp++; if (cred_seen != 1) begin n_err++; $display("FAIL postrst_credits got %0d want 1", cred_seen); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (axis_tvalid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_tvalid cyc %0d got %0b want %0b", c, axis_tvalid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_cmp++; if ({axis_tlast, axis_tdata} !== m_q[0]) begin n_err++; $display("FAIL rnd_beat cyc %0d got %0h want %0h", c, {axis_tlast, axis_tdata}, m_q[0]); end
            end
            n_cmp++; if (flow_ctrl_out !== m_credit) begin n_err++; $display("FAIL rnd_flow cyc %0d got %0b want %0b", c, flow_ctrl_out, m_credit); end
            n_cmp++; if (fifo_full !== (m_q.size() == DEPTH) || fifo_empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_flags cyc %0d got f%0b e%0b want occ %0d", c, fifo_full, fifo_empty, m_q.size()); end
            n_cmp++; if (err_overflow !== m_ovf || err_framing !== m_frm) begin n_err++; $display("FAIL rnd_err cyc %0d got o%0b f%0b want o%0b f%0b", c, err_overflow, err_framing, m_ovf, m_frm); end
            channel_in = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          AXIW'($urandom)};
            axis_tready = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        channel_in = '0;
        axis_tready = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_order%0d got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (cred_seen != exp_q.size()) begin n_err++; $display("FAIL rnd_credits got %0d want %0d", cred_seen, exp_q.size()); end
    endtask

`ifdef NOC2AXIS_STATS_EN
    task automatic test_stats();
        do_reset();
        axis_tready = 1'b1;
        channel_in = flit(1'b1, 1'b1, $urandom);
        @(negedge clk);
        channel_in = flit(1'b1, 1'b0, $urandom);
        @(negedge clk);
        channel_in = flit(1'b0, 1'b0, $urandom);
        @(negedge clk);
        channel_in = flit(1'b0, 1'b1, $urandom);
        @(negedge clk);
        channel_in = '0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_cmp++; if (flit_count !== 16'd4) begin n_err++; $display("FAIL stats_flits got %0d want 4", flit_count); end
        n_cmp++; if (pkt_count !== 16'd2) begin n_err++; $display("FAIL stats_pkts got %0d want 2", pkt_count); end
        for (int i = 0; i < 65532; i++) begin
            channel_in = flit(1'b1, 1'b1, $urandom);
            @(negedge clk);
        end
        channel_in = '0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        n_cmp++; if (flit_count !== 16'd0) begin n_err++; $display("FAIL stats_wrap got %0h want 0", flit_count); end
        n_cmp++; if (pkt_count !== 16'd65534) begin n_err++; $display("FAIL stats_pkts_big got %0d want 65534", pkt_count); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_packet();
        test_overflow();
        test_full_push_pop();
        test_framing_and_reset();
        test_random();
`ifdef NOC2AXIS_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_to_axis_adapter.md
Name: noc_to_axis_adapter

Overview:
Egress stage of the NoC-to-AXI-Stream bridge. Consumes flits from a router_slice output port (36-bit channel), buffers them in a DEPTH-entry FIFO and presents them as an AXI-Stream master. Returns one flow-control credit pulse to the router per flit drained. Mirror of axis_to_noc_adapter; sits on the same router port 4 in the opposite direction.

Parameters:
AXIW, 32, payload/tdata width; channel width is AXIW+4
DEPTH, 8, FIFO entries; power of two, >= 2; equals credits the router starts with

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
channel_in  in  AXIW+4  flit from router: [AXIW+3] valid, [AXIW+2] head, [AXIW+1] tail, [AXIW] reserved (ignored), [AXIW-1:0] payload
flow_ctrl_out  out  1  credit return to router, 1-cycle pulse per flit dequeued
axis_tvalid  out  1  AXIS beat valid
axis_tready  in  1  AXIS sink ready
axis_tdata  out  AXIW  flit payload
axis_tlast  out  1  tail flag of the flit
fifo_empty  out  1  FIFO occupancy == 0
fifo_full  out  1  FIFO occupancy == DEPTH
err_overflow  out  1  sticky: flit arrived while FIFO full and no pop that cycle
err_framing  out  1  sticky: head/tail sequence violation

Behaviour:
- Reset (async assert, sync use after deassert): FIFO pointers/count 0, state IDLE, axis_tvalid=0, axis_tdata=0, axis_tlast=0, flow_ctrl_out=0, fifo_empty=1, fifo_full=0, both error flags 0. Reset mid-packet flushes FIFO; no credits returned for flushed flits.
- Push: channel_in valid at edge N -> stored at edge N; axis_tvalid high from cycle N+1 (1-cycle latency, no combinational pass-through).
- Pop: on axis_tvalid & axis_tready at edge M, entry removed; flow_ctrl_out=1 during cycle M+1 only. Back-to-back pops -> flow_ctrl_out held high one cycle per pop.
- AXIS rules: axis_tdata/axis_tlast stable while axis_tvalid & !axis_tready; axis_tvalid never drops without handshake.
- Full + push + pop same edge: push accepted, occupancy stays DEPTH, no overflow.
- Full + push, no pop: flit dropped, err_overflow set (sticky until rst).
- Empty + push + pop: impossible (tvalid low); push stored normally.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Framing FSM, evaluated on each accepted push, states IDLE / IN_PKT:
  IDLE: head&tail -> IDLE (single-flit); head&!tail -> IN_PKT; !head -> err_framing, stay IDLE.
  IN_PKT: tail&!head -> IDLE; !head&!tail -> IN_PKT; head -> err_framing, treat as new head (-> IN_PKT, or IDLE if tail also set).
  Flits with framing errors are still stored and forwarded. Dropped (overflow) flits do not advance FSM.
- axis_tlast = stored tail bit; no header stripping.

Optional Feature:
Macro NOC2AXIS_STATS_EN. When defined: extra outputs flit_count[15:0] (increments per AXIS handshake) and pkt_count[15:0] (increments per handshake with axis_tlast=1); both reset to 0, wrap 16'hFFFF -> 0. When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single flit head|tail, payload 32'hAABBCCDD, tready=1 -> axis_tvalid one cycle after arrival, tdata=AABBCCDD, tlast=1, flow_ctrl_out pulse exactly 1 cycle after handshake.
- 3-flit packet (head 0x11223344, body 0x55667788, tail 0xDEADBEEF), tready=1 -> three beats in order, tlast only on third, 3 credit cycles, err_framing=0.
- tready=0, push 8 flits -> fifo_full=1, tdata holds first flit stable; 9th flit -> dropped, err_overflow=1; release tready -> exactly 8 beats, 8 credits.
- Full FIFO, tready=1 and new flit same edge -> no overflow, fifo_full stays 1, all 9 flits delivered in order.
- Body flit (no head) while IDLE -> err_framing=1, flit still delivered; rst pulse mid-packet -> all outputs to reset values, subsequent head|tail flit delivered cleanly.
- With NOC2AXIS_STATS_EN: 2 packets (1 + 3 flits) drained -> flit_count=4, pkt_count=2; preload to 16'hFFFF via 65535 beats (or force) + one beat -> 0.
